// File: rtl/ls_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : ls_port_arbiter_if
//  Description : Requester and local-store RAM signal bundle for the
//                local store port arbiter. The slave modport is the arbiter
//                side; the master modport is the requester/RAM side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ls_port_arbiter_if #(
    parameter int LS_ADDR_W = 14
);
    // DMA burst requester
    logic                 dma_req;
    logic                 dma_we;
    logic [LS_ADDR_W-1:0] dma_addr;
    logic [127:0]         dma_wdata;
    logic                 dma_gnt;
    logic                 dma_beat;
    logic [2:0]           dma_beat_idx;
    logic                 dma_rvalid;
    logic                 dma_done;

    // Load/store unit
    logic                 lsu_req;
    logic                 lsu_we;
    logic [LS_ADDR_W-1:0] lsu_addr;
    logic [127:0]         lsu_wdata;
    logic                 lsu_gnt;
    logic                 lsu_rvalid;

    // Instruction fetch
    logic                 if_req;
    logic [LS_ADDR_W-1:0] if_addr;
    logic                 if_gnt;
    logic                 if_rvalid;
    logic                 if_done;

    // Local store RAM port
    logic                 ls_en;
    logic                 ls_we;
    logic [LS_ADDR_W-1:0] ls_addr;
    logic [127:0]         ls_wdata;
    logic [127:0]         ls_rdata_in;
    logic [127:0]         ls_rdata;

    modport slave (
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_beat, dma_beat_idx, dma_rvalid, dma_done,
        input  lsu_req, lsu_we, lsu_addr, lsu_wdata,
        output lsu_gnt, lsu_rvalid,
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_done,
        output ls_en, ls_we, ls_addr, ls_wdata,
        input  ls_rdata_in,
        output ls_rdata
    );

    modport master (
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_beat, dma_beat_idx, dma_rvalid, dma_done,
        output lsu_req, lsu_we, lsu_addr, lsu_wdata,
        input  lsu_gnt, lsu_rvalid,
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_done,
        input  ls_en, ls_we, ls_addr, ls_wdata,
        output ls_rdata_in,
        input  ls_rdata
    );
endinterface
`default_nettype wire

// File: rtl/ls_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ls_port_arbiter
//  Description : Sequences the single-port local store among DMA bursts,
//                single-quadword LSU accesses and instruction-fetch bursts.
//                Fixed priority DMA > LSU > IFETCH, bursts non-preemptible.
//                Optional macro LS_ARB_IF_STARVE_GUARD_EN adds an IFETCH
//                starvation guard that promotes IFETCH after
//                IF_STARVE_LIMIT lost IDLE decisions.
//  Revision    : 1.0 - initial release
// ============================================================================
module ls_port_arbiter #(
    parameter int LS_ADDR_W       = 14,
    parameter int BURST_LEN       = 8,
    parameter int IF_STARVE_LIMIT = 32
) (
    input  wire logic        clk,
    input  wire logic        reset,
    ls_port_arbiter_if.slave bus
);

    localparam int BEAT_W = $clog2(BURST_LEN);

    // State encoding doubles as the read-return owner code
    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_LSU_ACC   = 2'd1;
    localparam logic [1:0] c_DMA_BURST = 2'd2;
    localparam logic [1:0] c_IF_BURST  = 2'd3;

    localparam logic [BEAT_W-1:0] c_LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    logic [1:0]           r_state;
    logic [BEAT_W-1:0]    r_beat;
    logic [LS_ADDR_W-1:0] r_addr;
    logic                 r_we;
    logic                 r_rd_valid;
    logic [1:0]           r_rd_owner;
    logic                 r_dma_done;
    logic                 r_if_done;

    logic [1:0]           w_pick;
    logic                 w_if_force;
    logic                 w_in_burst;

    assign w_in_burst = (r_state == c_DMA_BURST) || (r_state == c_IF_BURST);

    // IDLE decision: fixed priority, optionally overridden for a starved IFETCH
    always_comb begin
        w_pick = c_IDLE;
        if (w_if_force && bus.if_req) begin
            w_pick = c_IF_BURST;
        end else if (bus.dma_req) begin
            w_pick = c_DMA_BURST;
        end else if (bus.lsu_req) begin
            w_pick = c_LSU_ACC;
        end else if (bus.if_req) begin
            w_pick = c_IF_BURST;
        end
    end

    // Sequencer: latch the winner in IDLE, walk burst beats, emit done pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_beat     <= '0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_dma_done <= 1'b0;
            r_if_done  <= 1'b0;
        end else begin
            r_dma_done <= 1'b0;
            r_if_done  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_state <= w_pick;
                    r_beat  <= '0;
                    case (w_pick)
                        c_LSU_ACC: begin
                            r_addr <= bus.lsu_addr;
                            r_we   <= bus.lsu_we;
                        end
                        c_DMA_BURST: begin
                            r_addr <= bus.dma_addr;
                            r_we   <= bus.dma_we;
                        end
                        c_IF_BURST: begin
                            r_addr <= bus.if_addr;
                            r_we   <= 1'b0;
                        end
                        default: begin
                            r_addr <= r_addr;
                            r_we   <= r_we;
                        end
                    endcase
                end
                c_LSU_ACC: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_beat <= r_beat + BEAT_W'(1);
                    if (r_beat == c_LAST_BEAT) begin
                        r_state    <= c_IDLE;
                        r_dma_done <= (r_state == c_DMA_BURST);
                        r_if_done  <= (r_state == c_IF_BURST);
                    end
                end
            endcase
        end
    end

    // Track which requester owns the read data returning next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_owner <= c_IDLE;
        end else begin
            r_rd_valid <= bus.ls_en && !bus.ls_we;
            r_rd_owner <= r_state;
        end
    end

    // RAM command and handshake outputs decode from registers only
    assign bus.ls_en   = (r_state != c_IDLE);
    assign bus.ls_we   = ((r_state == c_LSU_ACC) || (r_state == c_DMA_BURST)) && r_we;
    // Bursts wrap inside the aligned block: low address bits come from the beat counter
    assign bus.ls_addr = (r_state == c_LSU_ACC) ? r_addr :
                         w_in_burst ? {r_addr[LS_ADDR_W-1:BEAT_W], r_beat} :
                         '0;

    assign bus.lsu_gnt      = (r_state == c_LSU_ACC);
    assign bus.dma_gnt      = (r_state == c_DMA_BURST) && (r_beat == '0);
    assign bus.if_gnt       = (r_state == c_IF_BURST) && (r_beat == '0);
    assign bus.dma_beat     = (r_state == c_DMA_BURST);
    assign bus.dma_beat_idx = bus.dma_beat ? 3'(r_beat) : 3'd0;

    assign bus.lsu_rvalid = r_rd_valid && (r_rd_owner == c_LSU_ACC);
    assign bus.dma_rvalid = r_rd_valid && (r_rd_owner == c_DMA_BURST);
    assign bus.if_rvalid  = r_rd_valid && (r_rd_owner == c_IF_BURST);
    assign bus.dma_done   = r_dma_done;
    assign bus.if_done    = r_if_done;

    assign bus.ls_rdata = bus.ls_rdata_in;

    // Write data steered from the active writer; zero otherwise
    always_comb begin
        bus.ls_wdata = '0;
        if ((r_state == c_LSU_ACC) && r_we) begin
            bus.ls_wdata = bus.lsu_wdata;
        end else if ((r_state == c_DMA_BURST) && r_we) begin
            bus.ls_wdata = bus.dma_wdata;
        end
    end

`ifdef LS_ARB_IF_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(IF_STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] c_STARVE_MAX = STARVE_W'(IF_STARVE_LIMIT);

    logic [STARVE_W-1:0] r_starve_cnt;

    assign w_if_force = (r_starve_cnt == c_STARVE_MAX);

    // Count IDLE decisions lost by a pending IFETCH, saturating at the limit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (bus.if_gnt) begin
            r_starve_cnt <= '0;
        end else if ((r_state == c_IDLE) && bus.if_req && (w_pick != c_IF_BURST) &&
                     (r_starve_cnt != c_STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
        end
    end
`else
    assign w_if_force = 1'b0;

    // The starvation limit only matters when the guard is built in
    if (IF_STARVE_LIMIT < 1) begin : g_starve_limit_unused
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ls_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ls_port_arbiter
//  Description : Scoreboard bench for ls_port_arbiter. Expected RAM commands
//                and read returns are queued when a request is issued and
//                popped as the arbiter drives the RAM port / rvalids.
//                Build with LS_ARB_IF_STARVE_GUARD_EN to exercise the guard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ls_port_arbiter;

    localparam int AW = 14;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    ls_port_arbiter_if #(.LS_ADDR_W(AW)) bus ();

    ls_port_arbiter #(
        .LS_ADDR_W       (AW),
        .BURST_LEN       (8),
        .IF_STARVE_LIMIT (4)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- local store RAM model ----------------
    logic [127:0] ram [int];
    always @(posedge clk) begin
        if (bus.ls_en && bus.ls_we) ram[int'(bus.ls_addr)] = bus.ls_wdata;
        if (bus.ls_en && !bus.ls_we)
            bus.ls_rdata_in <= ram.exists(int'(bus.ls_addr)) ? ram[int'(bus.ls_addr)] : '0;
    end

    // DMA engine supplies write data indexed by the current beat
    logic [127:0] dma_buf [8];
    assign bus.dma_wdata = dma_buf[bus.dma_beat_idx];

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [1:0]    src;   // 1 LSU, 2 DMA, 3 IF
        logic          we;
        logic [AW-1:0] addr;
        logic [127:0]  data;
        logic [2:0]    idx;
    } cmd_t;
    typedef struct {
        logic [1:0]   src;
        logic [127:0] data;
    } rd_t;

    cmd_t         exp_cmd [$];
    rd_t          exp_rd  [$];
    logic [127:0] shadow  [int];

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] shadow_rd(input logic [AW-1:0] a);
        return shadow.exists(int'(a)) ? shadow[int'(a)] : '0;
    endfunction

    function automatic void push_lsu(input logic we, input logic [AW-1:0] a, input logic [127:0] d);
        exp_cmd.push_back('{src: 2'd1, we: we, addr: a, data: d, idx: 3'd0});
        if (we) shadow[int'(a)] = d;
        else    exp_rd.push_back('{src: 2'd1, data: shadow_rd(a)});
    endfunction

    function automatic void push_burst(input logic [1:0] src, input logic we, input logic [AW-1:0] base);
        logic [AW-1:0] a;
        logic [127:0]  d;
        for (int k = 0; k < 8; k++) begin
            a = {base[AW-1:3], 3'(k)};
            d = we ? dma_buf[k] : '0;
            exp_cmd.push_back('{src: src, we: we, addr: a, data: d, idx: 3'(k)});
            if (we) shadow[int'(a)] = d;
            else    exp_rd.push_back('{src: src, data: shadow_rd(a)});
        end
    endfunction

    cmd_t       m_c;
    rd_t        m_r;
    logic [1:0] m_src;
    logic [2:0] m_rv;

    // Compare every RAM command and every read return against the queues
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.ls_en) begin
                chk("cmd_expected", 128'(exp_cmd.size() != 0), 128'(1));
                if (exp_cmd.size() != 0) begin
                    m_c   = exp_cmd.pop_front();
                    m_src = bus.lsu_gnt ? 2'd1 : (bus.dma_beat ? 2'd2 : 2'd3);
                    chk("cmd_src",  m_src,       m_c.src);
                    chk("cmd_we",   bus.ls_we,   m_c.we);
                    chk("cmd_addr", bus.ls_addr, m_c.addr);
                    if (m_c.we)        chk("cmd_wdata",    bus.ls_wdata,     m_c.data);
                    if (m_c.src == 2)  chk("dma_beat_idx", bus.dma_beat_idx, m_c.idx);
                end
            end
            m_rv = {bus.if_rvalid, bus.dma_rvalid, bus.lsu_rvalid};
            if (m_rv != 3'b000) begin
                chk("rvalid_onehot", 128'($countones(m_rv)), 128'(1));
                chk("rd_expected", 128'(exp_rd.size() != 0), 128'(1));
                if (exp_rd.size() != 0) begin
                    m_r   = exp_rd.pop_front();
                    m_src = bus.lsu_rvalid ? 2'd1 : (bus.dma_rvalid ? 2'd2 : 2'd3);
                    chk("rd_src",  m_src,        m_r.src);
                    chk("rd_data", bus.ls_rdata, m_r.data);
                end
            end
        end
    end

    // ---------------- requester helpers ----------------
    function automatic logic evt(input int w);
        case (w)
            0:       return bus.lsu_gnt;
            1:       return bus.dma_gnt;
            2:       return bus.if_gnt;
            3:       return bus.dma_done;
            default: return bus.if_done;
        endcase
    endfunction

    task automatic wait_evt(input int which, input string tag, output int at);
        at = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (evt(which)) begin
                at = cyc;
                break;
            end
        end
        chk({tag, "_seen"}, 128'(at >= 0), 128'(1));
    endtask

    task automatic lsu_op(input logic we, input logic [AW-1:0] a, input logic [127:0] d, output int g);
        bus.lsu_we    = we;
        bus.lsu_addr  = a;
        bus.lsu_wdata = d;
        bus.lsu_req   = 1'b1;
        wait_evt(0, "lsu_gnt", g);
        bus.lsu_req = 1'b0;
        if (!we) begin
            @(negedge clk);
            chk("lsu_rvalid_lat", bus.lsu_rvalid, 1'b1);
        end
    endtask

    task automatic dma_op(input logic we, input logic [AW-1:0] base, output int g, output int d);
        bus.dma_we   = we;
        bus.dma_addr = base;
        bus.dma_req  = 1'b1;
        wait_evt(1, "dma_gnt", g);
        bus.dma_req = 1'b0;
        wait_evt(3, "dma_done", d);
    endtask

    task automatic if_op(input logic [AW-1:0] base, output int g, output int d);
        bus.if_addr = base;
        bus.if_req  = 1'b1;
        wait_evt(2, "if_gnt", g);
        bus.if_req = 1'b0;
        wait_evt(4, "if_done", d);
    endtask

    task automatic start_cycle(output int c0);
        @(posedge clk);
        #1;
        c0 = cyc;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int c0, g, d, g2, d2, g3, ndma, ndma_at_if, quiet;

        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0;
        bus.lsu_req = 0; bus.lsu_we = 0; bus.lsu_addr = '0; bus.lsu_wdata = '0;
        bus.if_req  = 0; bus.if_addr = '0;
        for (int k = 0; k < 8; k++) dma_buf[k] = '0;

        // Reset state: every output zero
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ls_en",    bus.ls_en,    1'b0);
        chk("rst_ls_we",    bus.ls_we,    1'b0);
        chk("rst_ls_addr",  bus.ls_addr,  '0);
        chk("rst_ls_wdata", bus.ls_wdata, '0);
        chk("rst_gnts",     {bus.dma_gnt, bus.lsu_gnt, bus.if_gnt}, 3'b000);
        chk("rst_rvalids",  {bus.dma_rvalid, bus.lsu_rvalid, bus.if_rvalid}, 3'b000);
        chk("rst_dones",    {bus.dma_done, bus.if_done}, 2'b00);
        chk("rst_beat",     {bus.dma_beat, bus.dma_beat_idx}, 4'b0000);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // LSU store then load
        start_cycle(c0);
        push_lsu(1'b1, 14'h0010, {16{8'hA5}});
        lsu_op(1'b1, 14'h0010, {16{8'hA5}}, g);
        chk("lsu_st_gnt_lat", 128'(g - c0), 128'(1));
        start_cycle(c0);
        push_lsu(1'b0, 14'h0010, '0);
        lsu_op(1'b0, 14'h0010, '0, g);
        chk("lsu_ld_gnt_lat", 128'(g - c0), 128'(1));

        // DMA write burst at an unaligned base, then IF read of the same block
        for (int k = 0; k < 8; k++) dma_buf[k] = {4{32'hDA7A_0000 + 32'(k)}};
        start_cycle(c0);
        push_burst(2'd2, 1'b1, 14'h0043);
        dma_op(1'b1, 14'h0043, g, d);
        chk("dma_gnt_lat",  128'(g - c0), 128'(1));
        chk("dma_done_lat", 128'(d - g),  128'(8));
        start_cycle(c0);
        push_burst(2'd3, 1'b0, 14'h0040);
        if_op(14'h0040, g, d);
        chk("if_gnt_lat",  128'(g - c0), 128'(1));
        chk("if_done_lat", 128'(d - g),  128'(8));

        // All three requesters at once: DMA, then LSU, then IFETCH
        for (int k = 0; k < 8; k++) dma_buf[k] = {4{32'hBEEF_0000 + 32'(k * 3)}};
        start_cycle(c0);
        push_burst(2'd2, 1'b1, 14'h0080);
        push_lsu(1'b0, 14'h0043, '0);
        push_burst(2'd3, 1'b0, 14'h0085);
        fork
            dma_op(1'b1, 14'h0080, g, d);
            lsu_op(1'b0, 14'h0043, '0, g2);
            if_op(14'h0085, g3, d2);
        join
        chk("prio_dma_gnt", 128'(g - c0),  128'(1));
        chk("prio_lsu_gnt", 128'(g2 - c0), 128'(10));
        chk("prio_if_gnt",  128'(g3 - c0), 128'(12));

        // LSU request arriving mid IF burst waits for all eight beats
        start_cycle(c0);
        push_burst(2'd3, 1'b0, 14'h0040);
        push_lsu(1'b0, 14'h0081, '0);
        fork
            if_op(14'h0040, g, d);
            begin
                repeat (3) @(posedge clk);
                #1;
                lsu_op(1'b0, 14'h0081, '0, g2);
            end
        join
        chk("lsu_after_if", 128'(g2 - g), 128'(9));

        // Reset at beat 4 of a DMA read
        start_cycle(c0);
        push_burst(2'd2, 1'b0, 14'h0080);
        bus.dma_we   = 1'b0;
        bus.dma_addr = 14'h0080;
        bus.dma_req  = 1'b1;
        wait_evt(1, "dma_rd_gnt", g);
        bus.dma_req = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_ls_en",  bus.ls_en,      1'b0);
        chk("rst_mid_rvalid", bus.dma_rvalid, 1'b0);
        chk("rst_mid_done",   bus.dma_done,   1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_cmd.delete();
        exp_rd.delete();
        quiet = 0;
        repeat (12) begin
            @(negedge clk);
            quiet += int'(bus.dma_done) + int'(bus.dma_rvalid) + int'(bus.ls_en);
        end
        chk("post_rst_quiet", 128'(quiet), 128'(0));
        start_cycle(c0);
        push_burst(2'd2, 1'b0, 14'h0080);
        dma_op(1'b0, 14'h0080, g, d);
        chk("dma_restart_gnt", 128'(g - c0), 128'(1));
        chk("dma_restart_done", 128'(d - g), 128'(8));

        // Continuous DMA plus IFETCH: starvation behaviour
        for (int k = 0; k < 8; k++) dma_buf[k] = {4{32'h5EED_0000 + 32'(k)}};
        start_cycle(c0);
`ifdef LS_ARB_IF_STARVE_GUARD_EN
        for (int b = 0; b < 4; b++) push_burst(2'd2, 1'b1, 14'h0100);
        push_burst(2'd3, 1'b0, 14'h0040);
        push_burst(2'd2, 1'b1, 14'h0100);
`else
        for (int b = 0; b < 5; b++) push_burst(2'd2, 1'b1, 14'h0100);
        push_burst(2'd3, 1'b0, 14'h0040);
`endif
        ndma       = 0;
        ndma_at_if = -1;
        fork
            begin
                bus.dma_we   = 1'b1;
                bus.dma_addr = 14'h0100;
                bus.dma_req  = 1'b1;
                for (int b = 0; b < 5; b++) begin
                    wait_evt(1, "starve_dma_gnt", g);
                    ndma++;
                end
                bus.dma_req = 1'b0;
                wait_evt(3, "starve_dma_done", d);
            end
            begin
                bus.if_addr = 14'h0040;
                bus.if_req  = 1'b1;
                wait_evt(2, "starve_if_gnt", g2);
                ndma_at_if = ndma;
                bus.if_req = 1'b0;
                wait_evt(4, "starve_if_done", d2);
            end
        join
`ifdef LS_ARB_IF_STARVE_GUARD_EN
        chk("starve_dma_before_if", 128'(ndma_at_if), 128'(4));
`else
        chk("starve_dma_before_if", 128'(ndma_at_if), 128'(5));
`endif

        repeat (3) @(negedge clk);
        chk("sb_cmd_left", 128'(exp_cmd.size()), 128'(0));
        chk("sb_rd_left",  128'(exp_rd.size()),  128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
